ghash_ctrl: RTL

- Sequencer that computes a GHASH accumulation Y_i = (Y_{i-1} xor X_i) * H over a stream of 128-bit blocks (AAD, ciphertext, length block).
- Drives one shared iterative GF(2^128) multiplier (gfmul_v2) and holds its operands stable for the whole multiply.
- Sits between the AES-GCM top-level data path and gfmul_v2, and produces the pre-mask authentication tag S.

---
 rtl/ghash_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/ghash_ctrl.sv
// GHASH sequencer: folds a stream of 128-bit blocks into Y = (Y ^ X) * H
// using one external iterative GF(2^128) multiplier, and presents the final
// Y as the pre-mask tag S.
// Optional build macro: GHASH_TIMEOUT_EN adds a MUL-state watchdog that
// raises oError and returns to IDLE after TIMEOUT_CYCLES cycles.
//
// Handshakes: a block transfers on a rising iClk edge where iBlock_valid and
// oBlock_ready are both 1. The multiplier operands are valid while
// oMul_ctext_valid (== oMul_hashkey_valid) is 1 and do not change until the
// product is returned with iMul_result_valid; valid then stays low for at
// least one cycle, and until iMul_result_valid is seen low.
module ghash_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 16
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iStart,
  input  logic [127:0]     iHashkey,
  input  logic             iHashkey_valid,
  input  logic [127:0]     iBlock,
  input  logic             iBlock_valid,
  input  logic             iBlock_last,
  output logic             oBlock_ready,
  output logic [127:0]     oMul_ctext,
  output logic             oMul_ctext_valid,
  output logic [127:0]     oMul_hashkey,
  output logic             oMul_hashkey_valid,
  input  logic [127:0]     iMul_result,
  input  logic             iMul_result_valid,
  output logic [127:0]     oTag,
  output logic             oTag_valid,
  output logic [CNT_W-1:0] oBlk_cnt,
  output logic             oBusy,
  output logic             oError,
  // debug view of the FSM: 0 IDLE, 1 ACCEPT, 2 MUL, 3 GAP, 4 DONE
  output logic [2:0]       oState
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ACCEPT = 3'd1;
  localparam logic [2:0] S_MUL    = 3'd2;
  localparam logic [2:0] S_GAP    = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  // The watchdog counter is 16 bits wide, so the limit must fit in it.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("ghash_ctrl: TIMEOUT_CYCLES must be in 1..65535");
  end

  logic [2:0]       state_q, state_d;
  logic [127:0]     y_q, h_q, op_q, tag_q;
  logic             last_q;
  logic [CNT_W-1:0] cnt_q;
  logic             timeout;
  logic             mul_v;

  // iStart is honoured only outside MUL/GAP; in ACCEPT it beats a block.
  logic start_ok, accept, hkey_ok;
  assign start_ok = iStart && (state_q == S_IDLE || state_q == S_ACCEPT ||
                               state_q == S_DONE);
  assign accept   = (state_q == S_ACCEPT) && !iStart && iBlock_valid;
  assign hkey_ok  = iHashkey_valid && (state_q != S_MUL) && (state_q != S_GAP);

`ifdef GHASH_TIMEOUT_EN
  logic [15:0] wd_q;
  logic        err_q;
  assign timeout = (state_q == S_MUL) && !iMul_result_valid &&
                   (wd_q == 16'(TIMEOUT_CYCLES - 1));
  assign oError  = err_q;

  // Watchdog: reloads on block acceptance, counts while waiting in MUL;
  // the error flag is sticky until the next honoured iStart.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (accept)                 wd_q <= '0;
      else if (state_q == S_MUL)  wd_q <= wd_q + 16'd1;
      if (start_ok)               err_q <= 1'b0;
      else if (timeout)           err_q <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign oError  = 1'b0;
`endif

  // State register.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (iStart) state_d = S_ACCEPT;
      S_ACCEPT: if (!iStart && iBlock_valid) state_d = S_MUL;
      S_MUL: begin
        if (iMul_result_valid) state_d = S_GAP;
        else if (timeout)      state_d = S_IDLE;
      end
      S_GAP:    if (!iMul_result_valid) state_d = last_q ? S_DONE : S_ACCEPT;
      S_DONE:   if (iStart) state_d = S_ACCEPT;
      default:  state_d = S_IDLE;
    endcase
  end

  // Control outputs decoded from the current state.
  always_comb begin
    oBlock_ready = 1'b0;
    mul_v        = 1'b0;
    oBusy        = 1'b0;
    oTag_valid   = 1'b0;
    case (state_q)
      S_ACCEPT: oBlock_ready = !iStart;
      S_MUL: begin
        mul_v = 1'b1;
        oBusy = 1'b1;
      end
      S_GAP:  oBusy      = 1'b1;
      S_DONE: oTag_valid = 1'b1;
      default: ;
    endcase
  end

  // Accumulator, operand, key, tag and block counter.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      y_q    <= '0;
      h_q    <= '0;
      op_q   <= '0;
      tag_q  <= '0;
      last_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      if (start_ok) begin
        y_q   <= '0;
        cnt_q <= '0;
      end else if (accept) begin
        op_q   <= y_q ^ iBlock;
        last_q <= iBlock_last;
        cnt_q  <= cnt_q + 1'b1;
      end
      if (state_q == S_MUL && iMul_result_valid) y_q <= iMul_result;
      if (hkey_ok) h_q <= iHashkey;
      if (state_q == S_GAP && !iMul_result_valid && last_q) tag_q <= y_q;
    end
  end

  assign oMul_ctext         = op_q;
  assign oMul_hashkey       = h_q;
  assign oMul_ctext_valid   = mul_v;
  assign oMul_hashkey_valid = mul_v;
  assign oTag               = tag_q;
  assign oBlk_cnt           = cnt_q;
  assign oState             = state_q;

endmodule
